// File: rtl/amt_multi_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amt_multi_commit_pkg
// Description : Shared configuration, types and helpers for the architectural
//               map table (AMT). Geometry is set by the AMT_* localparams.
//               Optional feature macro: AMT_ZERO_REG_EN (arch reg 0 = tag 0).
// Revision    : 1.0 - initial release
// ============================================================================
package amt_multi_commit_pkg;

  localparam int AMT_C            = 2;   // commit channels per cycle
  localparam int AMT_ARCH_REG_NUM = 32;  // architectural registers
  localparam int AMT_PHY_REG_NUM  = 64;  // physical registers
  localparam int AMT_RESTORE_W    = 8;   // entries per restore beat

  localparam int TAG_W     = $clog2(AMT_PHY_REG_NUM);
  localparam int AIDX_W    = $clog2(AMT_ARCH_REG_NUM);
  localparam int AMT_BEATS = AMT_ARCH_REG_NUM / AMT_RESTORE_W;
  localparam int BEAT_W    = (AMT_BEATS > 1) ? $clog2(AMT_BEATS) : 1;

  typedef struct packed {
    logic              wr_en;
    logic [AIDX_W-1:0] arch_reg;
    logic [TAG_W-1:0]  phy_reg;
  } rob_amt_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] phy_reg;
  } amt_fl_t;

  typedef enum logic [0:0] {
    AMT_IDLE    = 1'b0,
    AMT_RESTORE = 1'b1
  } amt_state_e;

  // Only meaningful when ARCH_REG_NUM is not a power of two.
  function automatic logic arch_in_range(input logic [AIDX_W-1:0] a);
    return (int'(a) < AMT_ARCH_REG_NUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/amt_multi_commit_if.sv
`default_nettype none
// ============================================================================
// Module      : amt_multi_commit_if
// Description : Bundle of retire, freelist and restore signals of the AMT.
//               slave  : AMT side (consumes retire/rollback, drives the rest)
//               master : ROB/rename side
// Revision    : 1.0 - initial release
// ============================================================================
interface amt_multi_commit_if;
  import amt_multi_commit_pkg::*;

  rob_amt_t          rob_amt_i       [AMT_C];
  logic              rollback_i;
  logic [TAG_W-1:0]  amt_o           [AMT_ARCH_REG_NUM];
  amt_fl_t           fl_o            [AMT_C];
  logic              restore_valid_o;
  logic [AIDX_W-1:0] restore_base_o;
  logic [TAG_W-1:0]  restore_tag_o   [AMT_RESTORE_W];
  logic              restore_done_o;
  logic              busy_o;

  modport slave (
    input  rob_amt_i, rollback_i,
    output amt_o, fl_o, restore_valid_o, restore_base_o, restore_tag_o,
           restore_done_o, busy_o
  );

  modport master (
    output rob_amt_i, rollback_i,
    input  amt_o, fl_o, restore_valid_o, restore_base_o, restore_tag_o,
           restore_done_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/amt_multi_commit_restore_fsm.sv
`default_nettype none
// ============================================================================
// Module      : amt_restore_fsm
// Description : Rollback restore sequencer. Walks beat index 0..AMT_BEATS-1,
//               restarts on a new rollback, pulses done on the final beat of
//               an uninterrupted pass.
// Ports       : clk_i, rst_n_i (async, active low), i_rollback,
//               o_busy, o_valid, o_done, o_beat
// Revision    : 1.0 - initial release
// ============================================================================
module amt_restore_fsm
  import amt_multi_commit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              i_rollback,
  output logic              o_busy,
  output logic              o_valid,
  output logic              o_done,
  output logic [BEAT_W-1:0] o_beat
);

  amt_state_e        r_state, w_state_nxt;
  logic [BEAT_W-1:0] r_beat,  w_beat_nxt;
  logic              w_last;

  assign w_last = (r_beat == BEAT_W'(AMT_BEATS - 1));
  assign o_beat = r_beat;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= AMT_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    o_busy      = 1'b0;
    o_valid     = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      AMT_IDLE: begin
        if (i_rollback) begin
          w_state_nxt = AMT_RESTORE;
          w_beat_nxt  = '0;
        end
      end
      AMT_RESTORE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_rollback) begin
          // Restart: this pass is abandoned, so no done pulse for it.
          w_beat_nxt = '0;
        end else if (w_last) begin
          o_done      = 1'b1;
          w_state_nxt = AMT_IDLE;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt = r_beat + 1'b1;
        end
      end
      default: begin
        w_state_nxt = AMT_IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/amt_multi_commit.sv
`default_nettype none
// ============================================================================
// Module      : amt_multi_commit
// Description : Multi-commit architectural map table. Retire writes update
//               arch->phys mappings, displaced tags go to the freelist, and a
//               rollback streams the committed map out in beats.
//               Optional macro AMT_ZERO_REG_EN: arch reg 0 hardwired to tag 0.
// Ports       : clk_i, rst_n_i (async, active low), bus (amt_multi_commit_if
//               slave: rob_amt_i, rollback_i, amt_o, fl_o, restore_*, busy_o)
// Revision    : 1.0 - initial release
// ============================================================================
module amt_multi_commit
  import amt_multi_commit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  amt_multi_commit_if.slave bus
);

  generate
    if (AMT_ARCH_REG_NUM % AMT_RESTORE_W != 0) begin : g_cfg_chk
      $error("ARCH_REG_NUM must be a multiple of RESTORE_W");
    end
  endgenerate

  logic [TAG_W-1:0]  r_amt     [AMT_ARCH_REG_NUM];
  logic [TAG_W-1:0]  w_amt_nxt [AMT_ARCH_REG_NUM];
  amt_fl_t           r_fl      [AMT_C];
  amt_fl_t           w_fl_nxt  [AMT_C];
  logic [AMT_C-1:0]  w_wr_ok;
  logic [AMT_C-1:0]  w_wr_req;
  logic              w_busy;
  logic              w_valid;
  logic              w_done;
  logic [BEAT_W-1:0] w_beat;
  logic [AIDX_W-1:0] w_base;

  amt_restore_fsm u_restore_fsm (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .i_rollback (bus.rollback_i),
    .o_busy     (w_busy),
    .o_valid    (w_valid),
    .o_done     (w_done),
    .o_beat     (w_beat)
  );

  // A channel writes only outside restore, in range, and (optionally) not r0.
  always_comb begin
    for (int k = 0; k < AMT_C; k++) begin
      w_wr_req[k] = bus.rob_amt_i[k].wr_en;
      w_wr_ok[k]  = bus.rob_amt_i[k].wr_en && !w_busy &&
                    arch_in_range(bus.rob_amt_i[k].arch_reg);
`ifdef AMT_ZERO_REG_EN
      if (bus.rob_amt_i[k].arch_reg == '0) w_wr_ok[k] = 1'b0;
`endif
    end
  end

  // Displaced tag: the nearest lower channel hitting the same entry supplies
  // it, otherwise the pre-commit table value. Ascending write order lets the
  // highest channel own the entry.
  always_comb begin
    w_amt_nxt = r_amt;
    for (int k = 0; k < AMT_C; k++) begin
      w_fl_nxt[k].valid   = w_wr_ok[k];
      w_fl_nxt[k].phy_reg = w_wr_ok[k] ? r_amt[bus.rob_amt_i[k].arch_reg] : '0;
      for (int j = 0; j < k; j++) begin
        if (w_wr_ok[j] && w_wr_ok[k] &&
            (bus.rob_amt_i[j].arch_reg == bus.rob_amt_i[k].arch_reg)) begin
          w_fl_nxt[k].phy_reg = bus.rob_amt_i[j].phy_reg;
        end
      end
    end
    for (int k = 0; k < AMT_C; k++) begin
      if (w_wr_ok[k]) w_amt_nxt[bus.rob_amt_i[k].arch_reg] = bus.rob_amt_i[k].phy_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < AMT_ARCH_REG_NUM; i++) r_amt[i] <= TAG_W'(i);
      for (int k = 0; k < AMT_C; k++) r_fl[k] <= '0;
    end else begin
      r_amt <= w_amt_nxt;
      r_fl  <= w_fl_nxt;
    end
  end

  assign w_base              = AIDX_W'(int'(w_beat) * AMT_RESTORE_W);
  assign bus.amt_o           = r_amt;
  assign bus.fl_o            = r_fl;
  assign bus.restore_valid_o = w_valid;
  assign bus.restore_base_o  = w_base;
  assign bus.restore_done_o  = w_done;
  assign bus.busy_o          = w_busy;

  // Restore tags are read live from the table for the current beat window.
  generate
    for (genvar r = 0; r < AMT_RESTORE_W; r++) begin : g_tag
      assign bus.restore_tag_o[r] = w_valid ? r_amt[w_base + AIDX_W'(r)] : '0;
    end
  endgenerate

`ifndef SYNTHESIS
  a_no_commit_in_restore: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) !(w_busy && |w_wr_req))
    else $warning("amt_multi_commit: retire write during restore ignored");
`endif

endmodule
`default_nettype wire

// File: tb/tb_amt_multi_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_amt_multi_commit
// Description : Self-checking bench for amt_multi_commit with a map-table
//               reference model. Honours AMT_ZERO_REG_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amt_multi_commit;
  import amt_multi_commit_pkg::*;

  localparam int C = AMT_C;
  localparam int A = AMT_ARCH_REG_NUM;
  localparam int W = AMT_RESTORE_W;
  localparam int N = A / W;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Reference model state
  int   m_amt  [A];
  int   e_fl_v [C];
  int   e_fl_p [C];
  int   s_wr   [C];
  int   s_arch [C];
  int   s_phy  [C];

  amt_multi_commit_if bus();

  amt_multi_commit dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dropped(input int a);
`ifdef AMT_ZERO_REG_EN
    return (a == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < A; i++) m_amt[i] = i;
    for (int k = 0; k < C; k++) begin e_fl_v[k] = 0; e_fl_p[k] = 0; end
  endtask

  // Drive s_* onto the bus and advance the model by one retire cycle.
  task automatic drive_commit();
    int ok [C];
    for (int k = 0; k < C; k++) begin
      bus.rob_amt_i[k].wr_en    = (s_wr[k] != 0);
      bus.rob_amt_i[k].arch_reg = AIDX_W'(s_arch[k]);
      bus.rob_amt_i[k].phy_reg  = TAG_W'(s_phy[k]);
      ok[k] = (s_wr[k] != 0 && dropped(s_arch[k]) == 0) ? 1 : 0;
    end
    for (int k = 0; k < C; k++) begin
      e_fl_v[k] = ok[k];
      e_fl_p[k] = 0;
      if (ok[k] != 0) begin
        e_fl_p[k] = m_amt[s_arch[k]];
        for (int j = k - 1; j >= 0; j--) begin
          if (ok[j] != 0 && s_arch[j] == s_arch[k]) begin
            e_fl_p[k] = s_phy[j];
            break;
          end
        end
      end
    end
    for (int k = 0; k < C; k++) if (ok[k] != 0) m_amt[s_arch[k]] = s_phy[k];
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < C; k++) begin s_wr[k] = 0; s_arch[k] = 0; s_phy[k] = 0; end
    for (int k = 0; k < C; k++) bus.rob_amt_i[k] = '0;
    bus.rollback_i = 1'b0;
  endtask

  task automatic check_map(input string tag);
    for (int i = 0; i < A; i++) begin
      checks++;
      if (int'(bus.amt_o[i]) !== m_amt[i]) begin
        failures++;
        $display("FAIL %s amt[%0d]: got %0d expected %0d", tag, i, bus.amt_o[i], m_amt[i]);
      end
    end
  endtask

  task automatic check_fl(input string tag);
    for (int k = 0; k < C; k++) begin
      checks++;
      if (int'(bus.fl_o[k].valid) !== e_fl_v[k]) begin
        failures++;
        $display("FAIL %s fl[%0d].valid: got %0d expected %0d", tag, k, bus.fl_o[k].valid, e_fl_v[k]);
      end
      if (e_fl_v[k] != 0) begin
        checks++;
        if (int'(bus.fl_o[k].phy_reg) !== e_fl_p[k]) begin
          failures++;
          $display("FAIL %s fl[%0d].phy: got %0d expected %0d", tag, k, bus.fl_o[k].phy_reg, e_fl_p[k]);
        end
      end
    end
  endtask

  task automatic check_beat(input string tag, input int beat, input int exp_done);
    checks++;
    if (bus.restore_valid_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL %s beat%0d valid/busy: got %0d/%0d expected 1/1", tag, beat, bus.restore_valid_o, bus.busy_o);
    end
    checks++;
    if (int'(bus.restore_base_o) !== beat * W) begin
      failures++;
      $display("FAIL %s beat%0d base: got %0d expected %0d", tag, beat, bus.restore_base_o, beat * W);
    end
    checks++;
    if (int'(bus.restore_done_o) !== exp_done) begin
      failures++;
      $display("FAIL %s beat%0d done: got %0d expected %0d", tag, beat, bus.restore_done_o, exp_done);
    end
    for (int r = 0; r < W; r++) begin
      checks++;
      if (int'(bus.restore_tag_o[r]) !== m_amt[beat * W + r]) begin
        failures++;
        $display("FAIL %s beat%0d tag[%0d]: got %0d expected %0d", tag, beat, r, bus.restore_tag_o[r], m_amt[beat * W + r]);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.restore_valid_o !== 1'b0 || bus.restore_done_o !== 1'b0) begin
      failures++;
      $display("FAIL %s idle busy/valid/done: got %0d/%0d/%0d expected 0/0/0", tag, bus.busy_o, bus.restore_valid_o, bus.restore_done_o);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    check_map("reset");
    check_fl("reset");
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_dual_commit();
    s_wr[0] = 1; s_arch[0] = 4; s_phy[0] = 7;
    s_wr[1] = 1; s_arch[1] = 5; s_phy[1] = 8;
    drive_commit();
    tick();
    idle_inputs();
    check_map("dual");
    check_fl("dual");
    checks++;
    if (bus.amt_o[4] !== TAG_W'(7) || bus.amt_o[5] !== TAG_W'(8)) begin
      failures++;
      $display("FAIL dual direct: got %0d,%0d expected 7,8", bus.amt_o[4], bus.amt_o[5]);
    end
    drive_commit();
    tick();
    check_fl("dual_quiet");
  endtask

  task automatic test_collision();
    s_wr[0] = 1; s_arch[0] = 3; s_phy[0] = 40;
    s_wr[1] = 1; s_arch[1] = 3; s_phy[1] = 41;
    drive_commit();
    tick();
    idle_inputs();
    check_map("collision");
    check_fl("collision");
    checks++;
    if (bus.amt_o[3] !== TAG_W'(41) || bus.fl_o[1].phy_reg !== TAG_W'(40) || bus.fl_o[0].phy_reg !== TAG_W'(3)) begin
      failures++;
      $display("FAIL collision direct: got amt3=%0d fl0=%0d fl1=%0d expected 41,3,40", bus.amt_o[3], bus.fl_o[0].phy_reg, bus.fl_o[1].phy_reg);
    end
  endtask

  task automatic test_random_commits();
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < C; k++) begin
        s_wr[k]   = ($urandom_range(0, 3) != 0) ? 1 : 0;
        s_arch[k] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, A - 1);
        s_phy[k]  = $urandom_range(0, AMT_PHY_REG_NUM - 1);
      end
      drive_commit();
      tick();
      check_map("random");
      check_fl("random");
    end
    idle_inputs();
    drive_commit();
    tick();
  endtask

  task automatic test_rollback();
    s_wr[0] = 1; s_arch[0] = 6; s_phy[0] = 50;
    drive_commit();
    bus.rollback_i = 1'b1;
    tick();
    idle_inputs();
    for (int b = 0; b < N; b++) begin
      check_beat("rollback", b, (b == N - 1) ? 1 : 0);
      if (b == 0) begin
        checks++;
        if (bus.restore_tag_o[6] !== TAG_W'(50)) begin
          failures++;
          $display("FAIL rollback beat0 tag6: got %0d expected 50", bus.restore_tag_o[6]);
        end
      end
      tick();
    end
    check_idle("rollback_end");
    check_map("rollback_end");
  endtask

  task automatic test_restart();
    int busy_cnt, done_cnt, restarted, exp_beat, timed_out;
    busy_cnt = 0; done_cnt = 0; restarted = 0; exp_beat = 0; timed_out = 1;
    bus.rollback_i = 1'b1;
    tick();
    bus.rollback_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy_o !== 1'b1) begin timed_out = 0; break; end
      busy_cnt++;
      if (bus.restore_done_o === 1'b1) done_cnt++;
      check_beat("restart", exp_beat, (restarted != 0 && exp_beat == N - 1) ? 1 : 0);
      if (busy_cnt == 3 && restarted == 0) begin
        bus.rollback_i = 1'b1;
        restarted = 1;
        exp_beat = 0;
      end else begin
        exp_beat++;
      end
      tick();
      bus.rollback_i = 1'b0;
    end
    checks++;
    if (timed_out != 0) begin
      failures++;
      $display("FAIL restart timeout: busy still %0d after %0d cycles expected idle", bus.busy_o, busy_cnt);
    end
    checks++;
    if (busy_cnt !== N + 3) begin
      failures++;
      $display("FAIL restart busy cycles: got %0d expected %0d", busy_cnt, N + 3);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL restart done pulses: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_async_reset();
    s_wr[0] = 1; s_arch[0] = 9;  s_phy[0] = 33;
    s_wr[1] = 1; s_arch[1] = 12; s_phy[1] = 34;
    drive_commit();
    bus.rollback_i = 1'b1;
    tick();
    idle_inputs();
    tick();
    check_beat("arst_pre", 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle("arst");
    check_map("arst");
    check_fl("arst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("arst_after");
  endtask

  task automatic test_zero_reg();
    s_wr[0] = 1; s_arch[0] = 0; s_phy[0] = 9;
    drive_commit();
    tick();
    idle_inputs();
    check_map("zero_reg");
    check_fl("zero_reg");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    test_reset();
    test_dual_commit();
    test_collision();
    test_random_commits();
    test_rollback();
    test_restart();
    test_async_reset();
    test_zero_reg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/amt_multi_commit.md
Name: amt_multi_commit

Overview:
Architectural map table (AMT) for the OoO core, generalised in commit width, architectural register count, physical register count and restore bandwidth. Retiring ROB entries update arch-to-phys mappings. The displaced physical tag of each commit is returned to the free list. On rollback, the committed map is streamed to the speculative map table over several cycles through a restore FSM, and the full flat view stays available for single-cycle recovery.

Parameters:
C, 2, commit channels per cycle.
ARCH_REG_NUM, 32, architectural registers (entries).
PHY_REG_NUM, 64, physical registers; tag width TAG_W = $clog2(PHY_REG_NUM).
RESTORE_W, 8, entries streamed per restore beat; ARCH_REG_NUM % RESTORE_W == 0 (elaboration assertion).

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  asynchronous, active-low reset.
rob_amt_i  in  C x {wr_en, arch_reg[AIDX_W], phy_reg[TAG_W]}  retire writes; channel 0 is oldest.
rollback_i  in  1  squash/recovery request, single-cycle pulse.
amt_o  out  ARCH_REG_NUM x TAG_W  full registered map.
fl_o  out  C x {valid, phy_reg[TAG_W]}  freed tags, registered.
restore_valid_o  out  1  restore beat valid.
restore_base_o  out  AIDX_W  first arch index of the beat.
restore_tag_o  out  RESTORE_W x TAG_W  tags for entries base..base+RESTORE_W-1.
restore_done_o  out  1  pulse on the last beat.
busy_o  out  1  high while in RESTORE.

Behaviour:
- Reset: entry i = i. fl_o valid = 0. FSM = IDLE. All restore_* and busy_o = 0.
- Commit: when channel k has wr_en = 1, entry[arch_reg] takes phy_reg at the next edge. amt_o reflects it one cycle later; there is no bypass.
- Freed tag: fl_o[k] is registered. At the next edge, valid = wr_en and phy_reg = the mapping displaced by channel k.
- Same arch_reg on channels j < k in one cycle:
  - The higher channel wins the table entry.
  - fl_o[k].phy_reg = rob_amt_i[j].phy_reg (forwarded from the nearest lower matching channel).
  - fl_o[j] gets the prior table value.
  - This chains across all C channels.
- FSM IDLE -> RESTORE: rollback_i = 1 in IDLE.
  - Commits in the same cycle are applied first.
  - Beat 0 is driven in the cycle after rollback_i and reads the updated table.
- RESTORE:
  - Beat counter b runs 0..N-1, N = ARCH_REG_NUM/RESTORE_W.
  - Each cycle: restore_valid_o = 1, restore_base_o = b*RESTORE_W, and tags are read live from the table.
  - restore_done_o = 1 with beat N-1, then the FSM returns to IDLE. busy_o = 1 for exactly N cycles.
- rollback_i during RESTORE: counter resets and beat 0 is driven in the next cycle (restart). done is not pulsed for the aborted pass.
- wr_en during RESTORE: ignored (no table update, fl_o valid = 0). A simulation-only assertion flags it.
- Async reset mid-restore: immediate return to IDLE, table reinitialised, all outputs to reset values.
- Out-of-range arch_reg: cannot occur when ARCH_REG_NUM is a power of two; otherwise the write is ignored.

Optional Feature:
AMT_ZERO_REG_EN:
- Defined: arch reg 0 is hardwired to tag 0. Writes to it are dropped, fl_o valid = 0 for that channel, and the entry is excluded from forwarding.
- Undefined: arch reg 0 behaves like any other entry.

Decomposition:
- Shared package:
  - ROB_AMT struct and AMT_FL struct {valid, phy_reg}.
  - Constants TAG_W and AIDX_W.
  - Restore state enum {AMT_IDLE, AMT_RESTORE}.
- Sub-module amt_restore_fsm: state, beat counter, done/busy generation. It exports the beat index; the top performs the table slice read.

Test Plan:
- Reset -> amt_o[i] == i for all i; fl_o valid = 0; busy_o = 0.
- Dual commit ch0 {1,4,7}, ch1 {1,5,8} -> next cycle amt_o[4] = 7, amt_o[5] = 8; fl_o[0] = {1,4}, fl_o[1] = {1,5}.
- Collision: ch0 {1,3,40}, ch1 {1,3,41} -> amt_o[3] = 41; fl_o[0] = {1,3}; fl_o[1] = {1,40}.
- Rollback pulse with concurrent commit {1,6,50}, RESTORE_W = 8:
  - 4 beats with bases 0, 8, 16, 24.
  - Beat 0 tag[6] = 50; done_o on beat 3; busy_o high 4 cycles.
- Rollback re-pulsed at beat 2 -> restore restarts at base 0; total 7 busy cycles; a single done_o pulse.
- rst_n_i low during beat 1 -> immediate idle; map back to identity; with AMT_ZERO_REG_EN, commit {1,0,9} leaves amt_o[0] = 0 and fl_o invalid.
